// File: rtl/sys_ctrl_burst.sv
// System controller: decodes byte-serial command frames into register-file, ALU and TX traffic.
// Latency: RF strobes 1 cycle after the triggering byte; TX 1 cycle after Rd_D_VLD/OUT_VLD when busy=0.
// Backpressure: TX bytes are held while busy=1; each byte needs a busy high->low cycle before the next.
//
// Ports:
//   CLK, RST                  clock, async active-high reset
//   RX_P_Data, RX_D_VLD       received byte and its one-cycle valid pulse
//   busy                      synchronised UART TX busy
//   TX_P_Data, TX_D_VLD       byte to transmit and its one-cycle request
//   WrEn, RdEn, Addr, Wr_D    register-file write/read strobes, address, write data
//   Rd_D, Rd_D_VLD            register-file read data and valid
//   ALU_EN, ALU_FUN           one-cycle ALU start and function
//   ALU_OUT, OUT_VLD          ALU result and valid
//   CLK_EN                    ALU clock-gate enable
//   clk_div_en                UART clock-divider enable
//   frame_err                 one-cycle pulse on an aborted frame
module sys_ctrl_burst #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int BURST_MAX = 8,
   parameter int TIMEOUT   = 255,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [WIDTH-1:0]     RX_P_Data,
   input  logic                 RX_D_VLD,
   input  logic                 busy,
   output logic [WIDTH-1:0]     TX_P_Data,
   output logic                 TX_D_VLD,
   output logic                 WrEn,
   output logic                 RdEn,
   output logic [ADDR_W-1:0]    Addr,
   output logic [WIDTH-1:0]     Wr_D,
   input  logic [WIDTH-1:0]     Rd_D,
   input  logic                 Rd_D_VLD,
   output logic                 ALU_EN,
   output logic [3:0]           ALU_FUN,
   input  logic [2*WIDTH-1:0]   ALU_OUT,
   input  logic                 OUT_VLD,
   output logic                 CLK_EN,
   output logic                 clk_div_en,
   output logic                 frame_err
);

   localparam int CW = $clog2(BURST_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [WIDTH-1:0] OPC_WR   = WIDTH'(8'hAA);
   localparam logic [WIDTH-1:0] OPC_RD   = WIDTH'(8'hBB);
   localparam logic [WIDTH-1:0] OPC_ALU  = WIDTH'(8'hCC);
   localparam logic [WIDTH-1:0] OPC_ALUN = WIDTH'(8'hDD);
   localparam logic [WIDTH-1:0] OPC_BWR  = WIDTH'(8'hEE);
   localparam logic [WIDTH-1:0] OPC_BRD  = WIDTH'(8'hEF);

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUN,
      RF_WR, RF_RD, RD_WAIT, ALU_START, ALU_WAIT, TX_SEND, TX_HOLD
   } state_t;

   typedef enum logic [2:0] {
      OP_WR, OP_RD, OP_ALU, OP_ALUN, OP_BWR, OP_BRD
   } op_t;

   state_t             state;
   op_t                op_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [CW-1:0]      cnt_r;      // transfers still owed, including the current one
   logic [TW-1:0]      tmo_cnt;
   logic [3:0]         fun_r;
   logic [WIDTH-1:0]   tx_dat;
   logic [WIDTH-1:0]   tx_msb;
   logic               tx_more;    // ALU MSB byte still to be sent
   logic               busy_seen;  // TX_HOLD has observed busy=1 for the current byte

   logic is_get;
   logic tmo_expire;

   assign is_get     = state inside {GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUN};
   assign tmo_expire = (tmo_cnt == TW'(TIMEOUT - 1));

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(DEPTH - 1)) return '0;
      return a + 1'b1;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         op_r       <= OP_WR;
         addr_r     <= '0;
         cnt_r      <= '0;
         tmo_cnt    <= '0;
         fun_r      <= '0;
         tx_dat     <= '0;
         tx_msb     <= '0;
         tx_more    <= 1'b0;
         busy_seen  <= 1'b0;
         TX_P_Data  <= '0;
         TX_D_VLD   <= 1'b0;
         WrEn       <= 1'b0;
         RdEn       <= 1'b0;
         Addr       <= '0;
         Wr_D       <= '0;
         ALU_EN     <= 1'b0;
         ALU_FUN    <= '0;
         CLK_EN     <= 1'b0;
         clk_div_en <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         clk_div_en <= 1'b1;
         // single-cycle strobes
         TX_D_VLD   <= 1'b0;
         WrEn       <= 1'b0;
         RdEn       <= 1'b0;
         ALU_EN     <= 1'b0;
         ALU_FUN    <= '0;
         frame_err  <= 1'b0;

         if (is_get && !RX_D_VLD) begin
            // idle inside a frame; a byte in the expiry cycle takes the else branch instead
            if (tmo_expire) begin
               state     <= IDLE;
               frame_err <= 1'b1;
               tmo_cnt   <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
            // in every GET_* branch below RX_D_VLD is known to be high
            case (state)
               IDLE: begin
                  if (RX_D_VLD) begin
                     cnt_r <= CW'(1);
                     case (RX_P_Data)
                        OPC_WR:   begin op_r <= OP_WR;   state <= GET_ADDR; end
                        OPC_RD:   begin op_r <= OP_RD;   state <= GET_ADDR; end
                        OPC_ALU:  begin op_r <= OP_ALU;  state <= GET_OPA;  end
                        OPC_ALUN: begin op_r <= OP_ALUN; state <= GET_FUN;  end
                        OPC_BWR:  begin op_r <= OP_BWR;  state <= GET_ADDR; end
                        OPC_BRD:  begin op_r <= OP_BRD;  state <= GET_ADDR; end
                        default:  frame_err <= 1'b1;
                     endcase
                  end
               end
               GET_ADDR: begin
                  addr_r <= RX_P_Data[ADDR_W-1:0];
                  case (op_r)
                     OP_WR: state <= GET_DATA;
                     OP_RD: begin
                        RdEn  <= 1'b1;
                        Addr  <= RX_P_Data[ADDR_W-1:0];
                        state <= RF_RD;
                     end
                     default: state <= GET_CNT;
                  endcase
               end
               GET_CNT: begin
                  if (RX_P_Data == '0 || RX_P_Data > WIDTH'(BURST_MAX)) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     cnt_r <= CW'(RX_P_Data);
                     if (op_r == OP_BRD) begin
                        RdEn  <= 1'b1;
                        Addr  <= addr_r;
                        state <= RF_RD;
                     end else begin
                        state <= GET_DATA;
                     end
                  end
               end
               GET_DATA: begin
                  WrEn  <= 1'b1;
                  Addr  <= addr_r;
                  Wr_D  <= RX_P_Data;
                  state <= RF_WR;
               end
               GET_OPA: begin
                  WrEn   <= 1'b1;
                  Addr   <= '0;
                  addr_r <= '0;
                  Wr_D   <= RX_P_Data;
                  state  <= RF_WR;
               end
               GET_OPB: begin
                  WrEn   <= 1'b1;
                  Addr   <= ADDR_W'(1);
                  addr_r <= ADDR_W'(1);
                  Wr_D   <= RX_P_Data;
                  state  <= RF_WR;
               end
               GET_FUN: begin
                  fun_r  <= RX_P_Data[3:0];
                  CLK_EN <= 1'b1;   // gate opens one cycle ahead of ALU_EN
                  state  <= ALU_START;
               end
               RF_WR: begin
                  if (op_r == OP_ALU) begin
                     state <= (addr_r == '0) ? GET_OPB : GET_FUN;
                  end else if (cnt_r > CW'(1)) begin
                     cnt_r  <= cnt_r - 1'b1;
                     addr_r <= addr_inc(addr_r);
                     state  <= GET_DATA;
                  end else begin
                     state <= IDLE;
                  end
               end
               RF_RD, RD_WAIT: begin
                  if (Rd_D_VLD) begin
                     tx_more <= 1'b0;
                     tx_dat  <= Rd_D;
                     if (!busy) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_Data <= Rd_D;
                        busy_seen <= 1'b0;
                        state     <= TX_HOLD;
                     end else begin
                        state <= TX_SEND;
                     end
                  end else begin
                     state <= RD_WAIT;
                  end
               end
               ALU_START: begin
                  ALU_EN  <= 1'b1;
                  ALU_FUN <= fun_r;
                  state   <= ALU_WAIT;
               end
               ALU_WAIT: begin
                  if (OUT_VLD) begin
                     CLK_EN  <= 1'b0;
                     tx_msb  <= ALU_OUT[2*WIDTH-1:WIDTH];
                     tx_more <= 1'b1;
                     tx_dat  <= ALU_OUT[WIDTH-1:0];
                     if (!busy) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_Data <= ALU_OUT[WIDTH-1:0];
                        busy_seen <= 1'b0;
                        state     <= TX_HOLD;
                     end else begin
                        state <= TX_SEND;
                     end
                  end
               end
               TX_SEND: begin
                  if (!busy) begin
                     TX_D_VLD  <= 1'b1;
                     TX_P_Data <= tx_dat;
                     busy_seen <= 1'b0;
                     state     <= TX_HOLD;
                  end
               end
               TX_HOLD: begin
                  // the UART must acknowledge with busy high, then release it
                  if (!busy_seen) begin
                     if (busy) busy_seen <= 1'b1;
                  end else if (!busy) begin
                     if (tx_more) begin
                        tx_more <= 1'b0;
                        tx_dat  <= tx_msb;
                        state   <= TX_SEND;
                     end else if (op_r == OP_BRD && cnt_r > CW'(1)) begin
                        cnt_r  <= cnt_r - 1'b1;
                        addr_r <= addr_inc(addr_r);
                        Addr   <= addr_inc(addr_r);
                        RdEn   <= 1'b1;
                        state  <= RF_RD;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Bench for sys_ctrl_burst: scoreboarded frames against RF/ALU/UART models.
// Latency: checks RF strobe addresses/data, TX bytes, read-to-TX latency, ALU gating.
// Backpressure: UART model pulses busy after every TX byte; a hold input forces busy.
module tb_sys_ctrl_burst;
   localparam int WIDTH     = 8;
   localparam int DEPTH     = 16;
   localparam int BURST_MAX = 8;
   localparam int TIMEOUT   = 255;
   localparam int ADDR_W    = $clog2(DEPTH);

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic [WIDTH-1:0]    RX_P_Data = '0;
   logic                RX_D_VLD = 1'b0;
   logic                uart_busy = 1'b0;
   logic                hold_busy = 1'b0;
   wire                 busy = uart_busy | hold_busy;
   logic [WIDTH-1:0]    TX_P_Data;
   logic                TX_D_VLD;
   logic                WrEn, RdEn;
   logic [ADDR_W-1:0]   Addr;
   logic [WIDTH-1:0]    Wr_D;
   logic [WIDTH-1:0]    Rd_D = '0;
   logic                Rd_D_VLD = 1'b0;
   logic                ALU_EN;
   logic [3:0]          ALU_FUN;
   logic [2*WIDTH-1:0]  ALU_OUT = '0;
   logic                OUT_VLD = 1'b0;
   logic                CLK_EN, clk_div_en, frame_err;

   sys_ctrl_burst #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD), .busy(busy),
      .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .WrEn(WrEn), .RdEn(RdEn), .Addr(Addr),
      .Wr_D(Wr_D), .Rd_D(Rd_D), .Rd_D_VLD(Rd_D_VLD), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .ALU_OUT(ALU_OUT), .OUT_VLD(OUT_VLD), .CLK_EN(CLK_EN), .clk_div_en(clk_div_en),
      .frame_err(frame_err)
   );

   always #5 CLK = ~CLK;

   wire [29:0] outs = {TX_P_Data, TX_D_VLD, WrEn, RdEn, Addr, Wr_D, ALU_EN, ALU_FUN, CLK_EN, frame_err};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard queues
   logic [11:0] exp_wr_q[$];   // {addr, data}
   logic [3:0]  exp_rd_q[$];
   logic [7:0]  exp_tx_q[$];
   logic [7:0]  mem [DEPTH];
   logic [3:0]  exp_fun = '0;
   int          err_cnt = 0;
   int          exp_err = 0;

   logic busy_prev = 1'b0, rdv_prev = 1'b0, ferr_prev = 1'b0;
   logic alu_en_prev = 1'b0, clk_en_prev = 1'b0, outv_prev = 1'b0;
   logic wait_hi = 1'b0, wait_lo = 1'b0;

   // monitor
   always @(negedge CLK) begin
      if (!RST) begin
         if (WrEn) begin
            chk("wr_expected", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) chk("wr_addr_data", {Addr, Wr_D}, exp_wr_q.pop_front());
            mem[Addr] = Wr_D;
         end
         if (RdEn) begin
            chk("rd_expected", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) chk("rd_addr", Addr, exp_rd_q.pop_front());
         end
         if (rdv_prev && !busy_prev) chk("rd_to_tx_latency", TX_D_VLD, 1);
         if (TX_D_VLD) begin
            chk("tx_busy_low", busy_prev, 0);
            chk("tx_gate", {wait_hi, wait_lo}, 0);
            chk("tx_expected", exp_tx_q.size() != 0, 1);
            if (exp_tx_q.size() != 0) chk("tx_data", TX_P_Data, exp_tx_q.pop_front());
            wait_hi = 1'b1;
            wait_lo = 1'b0;
         end else if (wait_hi && busy) begin
            wait_hi = 1'b0;
            wait_lo = 1'b1;
         end else if (wait_lo && !busy) begin
            wait_lo = 1'b0;
         end
         if (frame_err) begin
            err_cnt++;
            chk("ferr_width", ferr_prev, 0);
         end
         if (ALU_EN) begin
            chk("clk_en_at_alu_en", CLK_EN, 1);
            chk("clk_en_lead", clk_en_prev, 1);
            chk("alu_fun", ALU_FUN, exp_fun);
         end
         if (alu_en_prev) chk("alu_en_width", ALU_EN, 0);
         if (OUT_VLD) chk("clk_en_hold", CLK_EN, 1);
         if (outv_prev) chk("clk_en_drop", CLK_EN, 0);
      end
      busy_prev   = busy;
      rdv_prev    = Rd_D_VLD;
      ferr_prev   = frame_err;
      alu_en_prev = ALU_EN;
      clk_en_prev = CLK_EN;
      outv_prev   = OUT_VLD;
   end

   // register-file read model: data one cycle after RdEn
   initial begin
      logic [ADDR_W-1:0] ra;
      forever begin
         @(negedge CLK);
         if (RdEn && !RST) begin
            ra = Addr;
            @(posedge CLK); #1;
            Rd_D = mem[ra];
            Rd_D_VLD = 1'b1;
            @(posedge CLK); #1;
            Rd_D_VLD = 1'b0;
         end
      end
   end

   // ALU model: result three cycles after ALU_EN, operands from RF addresses 0 and 1
   initial begin
      logic [3:0] f;
      logic [15:0] a, b;
      forever begin
         @(negedge CLK);
         if (ALU_EN && !RST) begin
            f = ALU_FUN;
            a = {8'h00, mem[0]};
            b = {8'h00, mem[1]};
            repeat (3) @(posedge CLK);
            #1;
            ALU_OUT = (f == 4'd0) ? a + b : (f == 4'd1) ? a - b : 16'h0000;
            OUT_VLD = 1'b1;
            @(posedge CLK); #1;
            OUT_VLD = 1'b0;
         end
      end
   end

   // UART model: busy rises two cycles after a TX request and stays high six cycles
   initial begin
      forever begin
         @(negedge CLK);
         if (TX_D_VLD && !RST) begin
            repeat (2) @(posedge CLK);
            #1 uart_busy = 1'b1;
            repeat (6) @(posedge CLK);
            #1 uart_busy = 1'b0;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   // caller is positioned just after a rising edge
   task automatic send_byte(input logic [7:0] b);
      RX_P_Data = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
   endtask

   task automatic sb(input logic [7:0] b);
      send_byte(b);
      idle(3);
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
      exp_wr_q.push_back({a, d});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_wr_q.size() + exp_rd_q.size() + exp_tx_q.size() != 0 || wait_hi || wait_lo) && n < 3000) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("drain_pending", exp_wr_q.size() + exp_rd_q.size() + exp_tx_q.size() + int'(wait_hi) + int'(wait_lo), 0);
      idle(4);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic seen;

      // reset state
      idle(3);
      chk("rst_outputs", outs, 0);
      chk("rst_clk_div_en", clk_div_en, 0);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("clk_div_en_after_rst", clk_div_en, 1);
      idle(2);

      // write then read
      push_wr(4'd5, 8'h3C);
      sb(8'hAA); sb(8'h05); sb(8'h3C);
      drain();
      exp_rd_q.push_back(4'd5);
      exp_tx_q.push_back(8'h3C);
      sb(8'hBB); sb(8'h05);
      drain();

      // burst write with wrap, then burst read back
      push_wr(4'd14, 8'h11); push_wr(4'd15, 8'h22); push_wr(4'd0, 8'h33);
      sb(8'hEE); sb(8'h0E); sb(8'h03); sb(8'h11); sb(8'h22); sb(8'h33);
      drain();
      exp_rd_q.push_back(4'd14); exp_rd_q.push_back(4'd15); exp_rd_q.push_back(4'd0);
      exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22); exp_tx_q.push_back(8'h33);
      sb(8'hEF); sb(8'h0E); sb(8'h03);
      drain();

      // read with TX held off by busy
      hold_busy = 1'b1;
      exp_rd_q.push_back(4'd15);
      exp_tx_q.push_back(8'h22);
      sb(8'hBB); sb(8'h2F);          // upper address bits ignored
      idle(20);
      chk("tx_held_while_busy", exp_tx_q.size(), 1);
      hold_busy = 1'b0;
      drain();

      // ALU with operands (add), then without operands (sub)
      exp_fun = 4'd0;
      push_wr(4'd0, 8'h0A); push_wr(4'd1, 8'h05);
      exp_tx_q.push_back(8'h0F); exp_tx_q.push_back(8'h00);
      sb(8'hCC); sb(8'h0A); sb(8'h05); sb(8'h00);
      drain();
      exp_fun = 4'd1;
      exp_tx_q.push_back(8'h05); exp_tx_q.push_back(8'h00);
      sb(8'hDD); sb(8'h01);
      drain();
      chk("err_count_clean", err_cnt, exp_err);

      // invalid frames
      sb(8'hEE); sb(8'h00); sb(8'h00);
      exp_err++;
      idle(3);
      chk("err_cnt_zero", err_cnt, exp_err);
      sb(8'hEF); sb(8'h00); sb(8'h09);
      exp_err++;
      idle(3);
      chk("err_cnt_over_max", err_cnt, exp_err);
      push_wr(4'd6, 8'h77);
      send_byte(8'h55);              // bad opcode immediately followed by a new one
      exp_err++;
      sb(8'hAA); sb(8'h06); sb(8'h77);
      drain();
      chk("err_cnt_bad_opc", err_cnt, exp_err);

      // burst of exactly BURST_MAX
      for (int i = 0; i < BURST_MAX; i++) push_wr(4'(3 + i), 8'(8'h40 + i));
      sb(8'hEE); sb(8'h03); sb(8'(BURST_MAX));
      for (int i = 0; i < BURST_MAX; i++) sb(8'(8'h40 + i));
      drain();
      chk("err_cnt_burst_max", err_cnt, exp_err);

      // timeout: abort after exactly TIMEOUT idle cycles
      sb(8'hAA); send_byte(8'h05);
      k = 0; seen = 1'b0;
      while (!seen && k < TIMEOUT + 20) begin
         @(posedge CLK); #1;
         k++;
         if (frame_err) seen = 1'b1;
      end
      exp_err++;
      chk("timeout_cycles", k, TIMEOUT);
      idle(3);
      chk("err_cnt_timeout", err_cnt, exp_err);

      // byte in the expiry cycle wins
      push_wr(4'd5, 8'h99);
      sb(8'hAA); send_byte(8'h05);
      idle(TIMEOUT - 1);
      send_byte(8'h99);
      drain();
      chk("err_cnt_expiry_byte", err_cnt, exp_err);

      // reset mid-burst
      push_wr(4'd8, 8'hA1); push_wr(4'd9, 8'hA2);
      sb(8'hEE); sb(8'h08); sb(8'h04); sb(8'hA1); sb(8'hA2);
      RST = 1'b1;
      #1;
      chk("rst_mid_outputs", outs, 0);
      chk("rst_mid_clk_div_en", clk_div_en, 0);
      idle(2);
      RST = 1'b0;
      idle(2);
      chk("err_cnt_after_rst", err_cnt, exp_err);
      push_wr(4'd7, 8'h5A);
      sb(8'hAA); sb(8'h07); sb(8'h5A);
      drain();
      chk("err_cnt_final", err_cnt, exp_err);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
